// File: rtl/face_detection_pkg.sv
// Shared constants for the host mailbox protocol: command and status words,
// data/pixel widths and frame geometry, plus the responder's state encoding.
package face_detection_pkg;

    localparam int DATA_WIDTH   = 13;
    localparam int PIXEL_WIDTH  = 8;
    localparam int FRAME_WIDTH  = 800;
    localparam int FRAME_HEIGHT = 600;
    localparam int COORD_WIDTH  = 10;

    // Host -> FPGA command words
    localparam logic [DATA_WIDTH-1:0] CMD_START_SEND_PIXEL  = 13'd1;
    localparam logic [DATA_WIDTH-1:0] CMD_STOP_SEND_PIXEL   = 13'd2;
    localparam logic [DATA_WIDTH-1:0] CMD_START_RECV_RESULT = 13'd3;
    localparam logic [DATA_WIDTH-1:0] CMD_STOP_RECV_RESULT  = 13'd4;
    localparam logic [DATA_WIDTH-1:0] CMD_CALL_RESET        = 13'd5;

    // FPGA -> host status words
    localparam logic [DATA_WIDTH-1:0] STS_IDLE      = 13'd10;
    localparam logic [DATA_WIDTH-1:0] STS_RX_PIXEL  = 13'd11;
    localparam logic [DATA_WIDTH-1:0] STS_RX_BUSY   = 13'd12;
    localparam logic [DATA_WIDTH-1:0] STS_TX_RESULT = 13'd13;
    localparam logic [DATA_WIDTH-1:0] STS_TX_WAIT   = 13'd14;
    localparam logic [DATA_WIDTH-1:0] STS_FINISH    = 13'd15;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_PIX_WAIT  = 4'd1,
        S_PIX_ARMED = 4'd2,
        S_PIX_OUT   = 4'd3,
        S_RES_WAIT  = 4'd4,
        S_RES_TELL  = 4'd5,
        S_RES_SHOW  = 4'd6,
        S_RES_ACK   = 4'd7,
        S_RES_DONE  = 4'd8
    } hs_state_t;

endpackage

// File: rtl/frame_coord_counter.sv
// Raster-order pixel coordinate iterator: advances x, wraps into y, and wraps
// both to zero after the last pixel of the frame.
module frame_coord_counter
    import face_detection_pkg::*;
#(
    parameter int FRAME_WIDTH  = face_detection_pkg::FRAME_WIDTH,
    parameter int FRAME_HEIGHT = face_detection_pkg::FRAME_HEIGHT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_clear,
    input  logic                   i_advance,
    output logic [COORD_WIDTH-1:0] o_x,
    output logic [COORD_WIDTH-1:0] o_y,
    output logic                   o_last
);

    logic [COORD_WIDTH-1:0] r_x;
    logic [COORD_WIDTH-1:0] r_y;
    logic                   w_x_end;
    logic                   w_y_end;

    assign w_x_end = (r_x == COORD_WIDTH'(FRAME_WIDTH - 1));
    assign w_y_end = (r_y == COORD_WIDTH'(FRAME_HEIGHT - 1));

    // Clear has priority over advance so an abort never leaves a stale step.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_advance) begin
            if (w_x_end) begin
                r_x <= '0;
                r_y <= w_y_end ? '0 : r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    assign o_x    = r_x;
    assign o_y    = r_y;
    assign o_last = w_x_end && w_y_end;

endmodule

// File: rtl/fpga_host_handshake_ctrl.sv
// FPGA-side mailbox responder: decodes host commands, forwards pixels to the
// detection pipeline and hands detection results back one word per handshake.
module fpga_host_handshake_ctrl
    import face_detection_pkg::*;
#(
    parameter int DATA_WIDTH   = face_detection_pkg::DATA_WIDTH,
    parameter int PIXEL_WIDTH  = face_detection_pkg::PIXEL_WIDTH,
    parameter int FRAME_WIDTH  = face_detection_pkg::FRAME_WIDTH,
    parameter int FRAME_HEIGHT = face_detection_pkg::FRAME_HEIGHT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   s_write,
    input  logic [DATA_WIDTH-1:0]  s_writedata,
    output logic [DATA_WIDTH-1:0]  s_readdata,
    output logic                   pix_valid,
    output logic [PIXEL_WIDTH-1:0] pix_data,
    output logic [COORD_WIDTH-1:0] pix_x,
    output logic [COORD_WIDTH-1:0] pix_y,
    output logic                   pix_last,
    input  logic                   pix_ready,
    input  logic                   res_valid,
    input  logic [DATA_WIDTH-1:0]  res_data,
    input  logic                   res_last,
    output logic                   res_ready,
    output logic                   frame_done
);

    hs_state_t              r_state;
    hs_state_t              w_state_next;
    logic [DATA_WIDTH-1:0]  r_readdata;
    logic [DATA_WIDTH-1:0]  w_readdata_next;
    logic                   r_pix_valid;
    logic                   w_pix_valid_next;
    logic [PIXEL_WIDTH-1:0] r_pix_data;
    logic                   r_res_ready;
    logic                   w_res_ready_next;
    logic                   r_frame_done;
    logic                   w_frame_done_next;
    logic [DATA_WIDTH-1:0]  r_res_word;
    logic                   r_res_last;

    logic w_cmd_reset;
    logic w_cmd_start_pix;
    logic w_cmd_start_recv;
    logic w_cmd_stop_recv;
    logic w_abort;
    logic w_pix_accept;
    logic w_res_seen;
    logic w_res_pop;
    logic w_coord_last;

    assign w_cmd_reset      = s_write && (s_writedata == DATA_WIDTH'(CMD_CALL_RESET));
    assign w_cmd_start_pix  = s_write && (s_writedata == DATA_WIDTH'(CMD_START_SEND_PIXEL));
    assign w_cmd_start_recv = s_write && (s_writedata == DATA_WIDTH'(CMD_START_RECV_RESULT));
    assign w_cmd_stop_recv  = s_write && (s_writedata == DATA_WIDTH'(CMD_STOP_RECV_RESULT));

    // In PIX_ARMED every write is raw pixel data, so 5 cannot abort there.
    assign w_abort      = w_cmd_reset && (r_state != S_PIX_ARMED);
    assign w_pix_accept = (r_state == S_PIX_OUT) && r_pix_valid && pix_ready;
    assign w_res_seen   = (r_state == S_RES_WAIT) && res_valid;
    assign w_res_pop    = (r_state == S_RES_SHOW) && w_cmd_stop_recv;

    frame_coord_counter #(
        .FRAME_WIDTH  (FRAME_WIDTH),
        .FRAME_HEIGHT (FRAME_HEIGHT)
    ) u_coord (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_abort),
        .i_advance (w_pix_accept),
        .o_x       (pix_x),
        .o_y       (pix_y),
        .o_last    (w_coord_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_readdata   <= DATA_WIDTH'(STS_IDLE);
            r_pix_valid  <= 1'b0;
            r_pix_data   <= '0;
            r_res_ready  <= 1'b0;
            r_frame_done <= 1'b0;
            r_res_word   <= '0;
            r_res_last   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_readdata   <= w_readdata_next;
            r_pix_valid  <= w_pix_valid_next;
            r_res_ready  <= w_res_ready_next;
            r_frame_done <= w_frame_done_next;
            if ((r_state == S_PIX_ARMED) && s_write) begin
                r_pix_data <= s_writedata[PIXEL_WIDTH-1:0];
            end
            // Latch the result so the host sees a stable word even if the source moves.
            if (w_res_seen) begin
                r_res_word <= res_data;
                r_res_last <= res_last;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_abort) begin
            w_state_next = S_PIX_WAIT;
        end else begin
            case (r_state)
                S_IDLE:      w_state_next = S_IDLE;
                S_PIX_WAIT: begin
                    if (w_cmd_start_pix) begin
                        w_state_next = S_PIX_ARMED;
                    end else if (w_cmd_start_recv && r_frame_done) begin
                        w_state_next = S_RES_WAIT;
                    end
                end
                S_PIX_ARMED: if (s_write) w_state_next = S_PIX_OUT;
                S_PIX_OUT:   if (w_pix_accept) w_state_next = S_PIX_WAIT;
                S_RES_WAIT:  if (res_valid) w_state_next = S_RES_TELL;
                S_RES_TELL:  w_state_next = S_RES_SHOW;
                S_RES_SHOW: begin
                    if (w_cmd_stop_recv) begin
                        w_state_next = r_res_last ? S_RES_DONE : S_RES_ACK;
                    end
                end
                S_RES_ACK:   if (w_cmd_start_recv) w_state_next = S_RES_WAIT;
                S_RES_DONE:  w_state_next = S_RES_DONE;
                default:     w_state_next = S_IDLE;
            endcase
        end
    end

    // Registered outputs are a function of the state being entered.
    always_comb begin
        w_readdata_next   = DATA_WIDTH'(STS_IDLE);
        w_pix_valid_next  = (w_state_next == S_PIX_OUT);
        w_res_ready_next  = w_res_pop;
        w_frame_done_next = r_frame_done;
        case (w_state_next)
            S_IDLE:      w_readdata_next = DATA_WIDTH'(STS_IDLE);
            S_PIX_WAIT:  w_readdata_next = DATA_WIDTH'(STS_RX_PIXEL);
            S_PIX_ARMED: w_readdata_next = DATA_WIDTH'(STS_RX_BUSY);
            S_PIX_OUT:   w_readdata_next = DATA_WIDTH'(STS_RX_BUSY);
            S_RES_WAIT:  w_readdata_next = DATA_WIDTH'(STS_TX_WAIT);
            S_RES_TELL:  w_readdata_next = DATA_WIDTH'(STS_TX_RESULT);
            S_RES_SHOW:  w_readdata_next = r_res_word;
            S_RES_ACK:   w_readdata_next = DATA_WIDTH'(STS_TX_WAIT);
            S_RES_DONE:  w_readdata_next = DATA_WIDTH'(STS_FINISH);
            default:     w_readdata_next = DATA_WIDTH'(STS_IDLE);
        endcase
        if (w_abort) begin
            w_frame_done_next = 1'b0;
        end else if (w_pix_accept && w_coord_last) begin
            w_frame_done_next = 1'b1;
        end
    end

    assign s_readdata = r_readdata;
    assign pix_valid  = r_pix_valid;
    assign pix_data   = r_pix_data;
    assign pix_last   = r_pix_valid && w_coord_last;
    assign res_ready  = r_res_ready;
    assign frame_done = r_frame_done;

endmodule
